// File: rtl/instr_encoder.sv
// RV32I instruction encoder with a 2-entry output FIFO and a saturating count of rejected requests.
// Optional ENC_IMM_CHECK_EN: treats shift imm[11:5] != 0 and lw with rd == 0 as illegal.
// state | meaning
// EMPTY | no entries, ins_valid low
// ONE   | head entry valid
// FULL  | head and tail valid, req_ready low
module instr_encoder #(
    parameter int ERRW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_fmt,
    input  logic [3:0]      req_op,
    input  logic [4:0]      req_rd,
    input  logic [4:0]      req_rs1,
    input  logic [4:0]      req_rs2,
    input  logic [11:0]     req_imm,
    output logic            ins_valid,
    input  logic            ins_ready,
    output logic [31:0]     ins_word,
    output logic            err,
    output logic [ERRW-1:0] err_cnt
);
    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t            state_q, state_d;
    logic [31:0]       head_q, head_d, tail_q, tail_d;
    logic              err_q, err_d;
    logic [ERRW-1:0]   err_cnt_q, err_cnt_d;

    logic        legal, is_shift, accept, push, pop;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] enc_word;

    always_comb begin
        f3       = 3'b000;
        f7       = 7'b0000000;
        legal    = 1'b0;
        is_shift = (req_fmt == 2'b01) &&
                   (req_op == 4'b0000 || req_op == 4'b0001 || req_op == 4'b0010);
        case (req_op)
            4'b0000: f3 = 3'b001;
            4'b0001: f3 = 3'b101;
            4'b0010: f3 = 3'b101;
            4'b1011: f3 = 3'b010;
            4'b1100: f3 = 3'b011;
            4'b1001: f3 = 3'b100;
            4'b1000: f3 = 3'b110;
            4'b0111: f3 = 3'b111;
            default: f3 = 3'b000;
        endcase
        if (req_op == 4'b0110 || req_op == 4'b0001) f7 = 7'b0100000;
        case (req_fmt)
            2'b00: legal = (req_op == 4'b0101) || (req_op == 4'b0110) || (req_op == 4'b0111) ||
                           (req_op == 4'b1000) || (req_op == 4'b1011) || (req_op == 4'b1100);
            2'b01: legal = (req_op == 4'b0101) || (req_op == 4'b0111) || (req_op == 4'b1000) ||
                           (req_op == 4'b1001) || (req_op == 4'b1011) || is_shift;
            default: legal = (req_op == 4'b0101);
        endcase
`ifdef ENC_IMM_CHECK_EN
        if (is_shift && req_imm[11:5] != 7'd0) legal = 1'b0;
        if (req_fmt == 2'b10 && req_rd == 5'd0) legal = 1'b0;
`endif
        case (req_fmt)
            2'b00: enc_word = {f7, req_rs2, req_rs1, f3, req_rd, 7'b0110011};
            2'b01: enc_word = is_shift ? {f7, req_imm[4:0], req_rs1, f3, req_rd, 7'b0010011}
                                       : {req_imm, req_rs1, f3, req_rd, 7'b0010011};
            2'b10: enc_word = {req_imm, req_rs1, 3'b010, req_rd, 7'b0000011};
            default: enc_word = {req_imm[11:5], req_rs2, req_rs1, 3'b010, req_imm[4:0], 7'b0100011};
        endcase
    end

    assign req_ready = (state_q != FULL);
    assign ins_valid = (state_q != EMPTY);
    assign ins_word  = head_q;
    assign err       = err_q;
    assign err_cnt   = err_cnt_q;

    assign accept = req_valid & req_ready;
    assign push   = accept & legal;
    assign pop    = ins_valid & ins_ready;

    always_comb begin
        state_d   = state_q;
        head_d    = head_q;
        tail_d    = tail_q;
        err_d     = accept & ~legal;
        err_cnt_d = err_cnt_q;
        if (err_d && !(&err_cnt_q)) err_cnt_d = err_cnt_q + 1'b1;
        case (state_q)
            EMPTY: if (push) begin
                head_d  = enc_word;
                state_d = ONE;
            end
            ONE: begin
                if (push && pop) begin
                    head_d = enc_word;
                end else if (push) begin
                    tail_d  = enc_word;
                    state_d = FULL;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            FULL: if (pop) begin
                head_d  = tail_q;
                state_d = ONE;
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= EMPTY;
            head_q    <= '0;
            tail_q    <= '0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: driver queues expected words, negedge monitor checks them.
module tb_instr_encoder;
    localparam int ERRW = 8;
    localparam int CMAX = (1 << ERRW) - 1;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic [1:0]      req_fmt = '0;
    logic [3:0]      req_op = '0;
    logic [4:0]      req_rd = '0, req_rs1 = '0, req_rs2 = '0;
    logic [11:0]     req_imm = '0;
    logic            ins_valid;
    logic            ins_ready = 1'b0;
    logic [31:0]     ins_word;
    logic            err;
    logic [ERRW-1:0] err_cnt;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;
    logic [31:0] exp_q[$];
    logic        hold_v = 1'b0;
    logic [31:0] hold_w = '0;

    instr_encoder #(.ERRW(ERRW)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_fmt(req_fmt), .req_op(req_op), .req_rd(req_rd), .req_rs1(req_rs1),
        .req_rs2(req_rs2), .req_imm(req_imm), .ins_valid(ins_valid), .ins_ready(ins_ready),
        .ins_word(ins_word), .err(err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v && ins_valid) chk("ins_word_stable", ins_word, hold_w);
            if (ins_valid && ins_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got 0x%08h with empty scoreboard", ins_word);
                end else begin
                    chk("ins_word_order", ins_word, exp_q.pop_front());
                end
            end
            hold_v = ins_valid && !ins_ready;
            hold_w = ins_word;
        end
    end

    task automatic send(input logic [1:0] f, input logic [3:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [11:0] imm,
                        input logic legal, input logic [31:0] w);
        bit done = 0;
        req_fmt = f; req_op = op; req_rd = rd; req_rs1 = rs1; req_rs2 = rs2; req_imm = imm;
        req_valid = 1'b1;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (req_ready) begin
                if (legal) exp_q.push_back(w);
                else if (exp_cnt < CMAX) exp_cnt++;
                @(posedge clk);
                #1;
                done = 1;
            end
        end
        req_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: req_ready never high, got 0 expected 1");
        end else begin
            chk("err_after_accept", {31'd0, err}, {31'd0, ~legal});
            chk("err_cnt", {24'd0, err_cnt}, exp_cnt);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 30 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        chk("drain_remaining", exp_q.size(), 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ins_valid", {31'd0, ins_valid}, 0);
        chk("rst_ins_word", ins_word, 0);
        chk("rst_err", {31'd0, err}, 0);
        chk("rst_err_cnt", {24'd0, err_cnt}, 0);
        chk("rst_req_ready", {31'd0, req_ready}, 1);
        rst = 1'b0;
        ins_ready = 1'b1;
        @(posedge clk); #1;

        send(2'b00, 4'b0101, 5'd3, 5'd1, 5'd2, 12'h000, 1, 32'h002081B3);
        chk("latency_ins_valid", {31'd0, ins_valid}, 1);
        chk("latency_ins_word", ins_word, 32'h002081B3);
        send(2'b01, 4'b0101, 5'd5, 5'd0, 5'd0, 12'hFFF, 1, 32'hFFF00293);
        chk("one_hold_valid", {31'd0, ins_valid}, 1);
        chk("one_hold_ready", {31'd0, req_ready}, 1);
        send(2'b01, 4'b0001, 5'd6, 5'd7, 5'd0, 12'h003, 1, 32'h4033D313);
        send(2'b10, 4'b0101, 5'd4, 5'd1, 5'd0, 12'd16, 1, 32'h0100A203);
        send(2'b11, 4'b0101, 5'd0, 5'd1, 5'd2, 12'd8, 1, 32'h0020A423);
        chk("one_hold_ready2", {31'd0, req_ready}, 1);
        drain();
        @(posedge clk); #1;
        chk("empty_after_drain", {31'd0, ins_valid}, 0);

        send(2'b00, 4'b1001, 5'd3, 5'd1, 5'd2, 12'h000, 0, 32'h0);
        chk("illegal_no_valid", {31'd0, ins_valid}, 0);
        @(posedge clk); #1;
        chk("err_one_cycle", {31'd0, err}, 0);
        chk("illegal_still_empty", {31'd0, ins_valid}, 0);

`ifdef ENC_IMM_CHECK_EN
        send(2'b01, 4'b0000, 5'd1, 5'd1, 5'd0, 12'h020, 0, 32'h0);
        send(2'b10, 4'b0101, 5'd0, 5'd1, 5'd0, 12'd16, 0, 32'h0);
`else
        send(2'b01, 4'b0000, 5'd1, 5'd1, 5'd0, 12'h020, 1, 32'h00009093);
        send(2'b10, 4'b0101, 5'd0, 5'd1, 5'd0, 12'd16, 1, 32'h0100A003);
`endif
        drain();

        ins_ready = 1'b0;
        send(2'b00, 4'b0110, 5'd1, 5'd2, 5'd3, 12'h000, 1, 32'h403100B3);
        send(2'b00, 4'b1100, 5'd4, 5'd5, 5'd6, 12'h000, 1, 32'h0062B233);
        chk("full_req_ready", {31'd0, req_ready}, 0);
        fork
            send(2'b01, 4'b1000, 5'd7, 5'd8, 5'd0, 12'h0AB, 1, 32'h0AB46393);
            begin
                repeat (3) begin
                    @(posedge clk); #1;
                    chk("full_stays_full", {31'd0, req_ready}, 0);
                end
                ins_ready = 1'b1;
            end
        join
        drain();

        for (int i = 0; i < (1 << ERRW) + 3; i++)
            send(2'b10, 4'b0000, 5'd1, 5'd1, 5'd0, 12'h000, 0, 32'h0);
        chk("err_cnt_saturated", {24'd0, err_cnt}, CMAX);

        ins_ready = 1'b0;
        send(2'b00, 4'b0111, 5'd9, 5'd10, 5'd11, 12'h000, 1, 32'h00B574B3);
        send(2'b00, 4'b1011, 5'd12, 5'd13, 5'd14, 12'h000, 1, 32'h00E6A633);
        chk("pre_rst_full", {31'd0, req_ready}, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        exp_q.delete();
        exp_cnt = 0;
        chk("flush_ins_valid", {31'd0, ins_valid}, 0);
        chk("flush_req_ready", {31'd0, req_ready}, 1);
        chk("flush_err_cnt", {24'd0, err_cnt}, 0);
        chk("flush_ins_word", ins_word, 0);
        rst = 1'b0;
        ins_ready = 1'b1;
        @(posedge clk); #1;
        chk("post_flush_no_output", {31'd0, ins_valid}, 0);
        send(2'b01, 4'b0111, 5'd15, 5'd16, 5'd0, 12'h7FF, 1, 32'h7FF87793);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
